// File: rtl/multicycle_controller.sv
// Control unit for the multicycle RV32I core. A Moore state machine steps
// each instruction through fetch, decode, execute, memory and writeback. The
// steps share one ALU and one unified memory. The block also holds the ALU
// decoder and the immediate-format decode, so the datapath needs no other
// control logic.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  state_t     state;
  state_t     nextState;
  logic [1:0] aluOp;
  logic       pcUpdate;
  logic       branch;
  logic       adrSrcRaw;
  logic       memWriteRaw;
  logic       irWriteRaw;
  logic       regWriteRaw;
  logic       illegalRaw;
  logic [1:0] resultSrcRaw;
  logic [1:0] aluSrcARaw;
  logic [1:0] aluSrcBRaw;

  // Immediate format depends on the opcode only, never on the state.
  function automatic logic [1:0] immDecode(input logic [6:0] opc);
    case (opc)
      OP_LW, OP_I: immDecode = IMM_I;
      OP_SW:       immDecode = IMM_S;
      OP_BEQ:      immDecode = IMM_B;
      OP_JAL:      immDecode = IMM_J;
      default:     immDecode = IMM_I;
    endcase
  endfunction

  // ALU operation from the coarse ALUOp class plus the funct fields. Only
  // R-type (op[5] set) may select subtract. For I-type, bit 30 belongs to the
  // immediate.
  function automatic logic [2:0] aluDecode(input logic [1:0] cls,
                                           input logic [2:0] f3,
                                           input logic       opb5,
                                           input logic       f7b5);
    aluDecode = ALU_ADD;
    case (cls)
      2'b00: aluDecode = ALU_ADD;
      2'b01: aluDecode = ALU_SUB;
      2'b10: begin
        case (f3)
          3'b000:  aluDecode = (opb5 & f7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluDecode = ALU_SLT;
          3'b110:  aluDecode = ALU_OR;
          3'b111:  aluDecode = ALU_AND;
          default: aluDecode = ALU_ADD;
        endcase
      end
      default: aluDecode = ALU_ADD;
    endcase
  endfunction

  // Opcodes that this control unit knows how to sequence.
  function automatic logic opSupported(input logic [6:0] opc);
    case (opc)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: opSupported = 1'b1;
      default:                                  opSupported = 1'b0;
    endcase
  endfunction

  // State register; reset parks the machine in FETCH.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  // Next-state logic: DECODE dispatches on the opcode, every path ends in FETCH.
  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH: nextState = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_R:         nextState = EXECUTER;
          OP_I:         nextState = EXECUTEI;
          OP_BEQ:       nextState = BEQ;
          OP_JAL:       nextState = JAL;
          default:      nextState = FETCH;
        endcase
      end
      MEMADR:   nextState = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  nextState = MEMWB;
      EXECUTER: nextState = ALUWB;
      EXECUTEI: nextState = ALUWB;
      JAL:      nextState = ALUWB;
      MEMWB:    nextState = FETCH;
      MEMWRITE: nextState = FETCH;
      ALUWB:    nextState = FETCH;
      BEQ:      nextState = FETCH;
      default:  nextState = FETCH;
    endcase
  end

  // Per-state Moore outputs. Illegal also depends on the opcode seen in DECODE.
  always_comb begin
    aluOp        = 2'b00;
    pcUpdate     = 1'b0;
    branch       = 1'b0;
    adrSrcRaw    = 1'b0;
    memWriteRaw  = 1'b0;
    irWriteRaw   = 1'b0;
    regWriteRaw  = 1'b0;
    illegalRaw   = 1'b0;
    resultSrcRaw = 2'b00;
    aluSrcARaw   = 2'b00;
    aluSrcBRaw   = 2'b00;
    case (state)
      FETCH: begin
        adrSrcRaw    = 1'b0;
        irWriteRaw   = 1'b1;
        aluSrcARaw   = 2'b00;
        aluSrcBRaw   = 2'b10;
        aluOp        = 2'b00;
        resultSrcRaw = 2'b10;
        pcUpdate     = 1'b1;
      end
      DECODE: begin
        // Precompute the branch target OldPC + imm while the opcode is decoded.
        aluSrcARaw = 2'b01;
        aluSrcBRaw = 2'b01;
        aluOp      = 2'b00;
        illegalRaw = ~opSupported(op);
      end
      MEMADR: begin
        aluSrcARaw = 2'b10;
        aluSrcBRaw = 2'b01;
        aluOp      = 2'b00;
      end
      MEMREAD: begin
        resultSrcRaw = 2'b00;
        adrSrcRaw    = 1'b1;
      end
      MEMWB: begin
        resultSrcRaw = 2'b01;
        regWriteRaw  = 1'b1;
      end
      MEMWRITE: begin
        resultSrcRaw = 2'b00;
        adrSrcRaw    = 1'b1;
        memWriteRaw  = 1'b1;
      end
      EXECUTER: begin
        aluSrcARaw = 2'b10;
        aluSrcBRaw = 2'b00;
        aluOp      = 2'b10;
      end
      EXECUTEI: begin
        aluSrcARaw = 2'b10;
        aluSrcBRaw = 2'b01;
        aluOp      = 2'b10;
      end
      ALUWB: begin
        resultSrcRaw = 2'b00;
        regWriteRaw  = 1'b1;
      end
      BEQ: begin
        // The ALU compares rs1 and rs2. The target latched in DECODE sits in ALUOut.
        aluSrcARaw   = 2'b10;
        aluSrcBRaw   = 2'b00;
        aluOp        = 2'b01;
        resultSrcRaw = 2'b00;
        branch       = 1'b1;
      end
      JAL: begin
        // The ALU forms the link address OldPC + 4. The PC loads the jump target from ALUOut.
        aluSrcARaw   = 2'b01;
        aluSrcBRaw   = 2'b10;
        aluOp        = 2'b00;
        resultSrcRaw = 2'b00;
        pcUpdate     = 1'b1;
      end
      default: begin
        aluOp = 2'b00;
      end
    endcase
  end

  // Output stage: reset forces every output to 0, including in mid-instruction states.
  always_comb begin
    PCWrite    = pcUpdate | (branch & Zero);
    AdrSrc     = adrSrcRaw;
    MemWrite   = memWriteRaw;
    IRWrite    = irWriteRaw;
    RegWrite   = regWriteRaw;
    Illegal    = illegalRaw;
    ResultSrc  = resultSrcRaw;
    ALUSrcA    = aluSrcARaw;
    ALUSrcB    = aluSrcBRaw;
    ImmSrc     = immDecode(op);
    ALUControl = aluDecode(aluOp, funct3, op[5], funct7b5);
    if (reset) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      Illegal    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ImmSrc     = 2'b00;
      ALUControl = 3'b000;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. It applies table-driven instruction
// vectors, a reset-abort sequence and randomized instruction streams. Every
// output is checked each cycle against a per-instruction cycle schedule.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [16:0] outs;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .RegWrite(RegWrite), .Illegal(Illegal)
  );

  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ImmSrc, ALUControl, RegWrite, Illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] pk(input logic pcw, input logic adr,
      input logic mw, input logic irw, input logic [1:0] rs,
      input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] imm,
      input logic [2:0] alu, input logic rw, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ill};
  endfunction

  function automatic bit known(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
           (o == OP_BEQ) || (o == OP_JAL);
  endfunction

  // Clock cycles each instruction class takes, FETCH included.
  function automatic int cpi(input logic [6:0] o);
    if (o == OP_LW) return 5;
    if (o == OP_SW || o == OP_R || o == OP_I || o == OP_JAL) return 4;
    if (o == OP_BEQ) return 3;
    return 2;
  endfunction

  // Expected outputs in cycle k of one instruction, from the instruction's meaning.
  function automatic logic [16:0] modelOut(input logic [6:0] o,
      input logic [2:0] f3, input logic f7, input logic z, input int k);
    logic [1:0] imm;
    logic [2:0] fn;
    imm = (o == OP_SW) ? 2'd1 : (o == OP_BEQ) ? 2'd2 : (o == OP_JAL) ? 2'd3 : 2'd0;
    case (f3)
      3'd0:    fn = (o == OP_R && f7) ? 3'd1 : 3'd0;
      3'd2:    fn = 3'd5;
      3'd6:    fn = 3'd3;
      3'd7:    fn = 3'd2;
      default: fn = 3'd0;
    endcase
    if (k == 0) return pk(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd2, imm, 3'd0, 1'b0, 1'b0);
    if (k == 1) return pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, imm, 3'd0, 1'b0, !known(o));
    if (o == OP_LW || o == OP_SW) begin
      if (k == 2) return pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, imm, 3'd0, 1'b0, 1'b0);
      if (k == 3) return pk(1'b0, 1'b1, o == OP_SW, 1'b0, 2'd0, 2'd0, 2'd0, imm, 3'd0, 1'b0, 1'b0);
      if (k == 4 && o == OP_LW)
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, imm, 3'd0, 1'b1, 1'b0);
    end else if (o == OP_R || o == OP_I) begin
      if (k == 2) return pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, (o == OP_I) ? 2'd1 : 2'd0, imm, fn, 1'b0, 1'b0);
      if (k == 3) return pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, imm, 3'd0, 1'b1, 1'b0);
    end else if (o == OP_BEQ) begin
      if (k == 2) return pk(z, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, imm, 3'd1, 1'b0, 1'b0);
    end else if (o == OP_JAL) begin
      if (k == 2) return pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, imm, 3'd0, 1'b0, 1'b0);
      if (k == 3) return pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, imm, 3'd0, 1'b1, 1'b0);
    end
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, imm, 3'd0, 1'b0, 1'b0);
  endfunction

  task automatic check(input logic [16:0] got, input logic [16:0] want, input string nm);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%05h want=%05h", nm, got, want);
    end
  endtask

  // Runs nCyc cycles of one instruction, entered at posedge+1.
  // zeroSel 0/1 drives Zero constant; 2 drives it randomly each cycle.
  task automatic runInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
      input int zeroSel, input int nCyc, input int keyK, input logic [16:0] keyExp,
      input string nm);
    for (int k = 0; k < nCyc; k++) begin
      op       = o;
      funct3   = f3;
      funct7b5 = f7;
      Zero     = (zeroSel == 2) ? 1'($urandom_range(0, 1)) : (zeroSel == 1);
      @(negedge clk);
      check(outs, modelOut(o, f3, f7, Zero, k), $sformatf("%s_c%0d", nm, k));
      if (k == keyK) check(outs, keyExp, $sformatf("%s_key", nm));
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    int          zero;
    int          cycles;
    int          keyK;
    logic [16:0] keyExp;
    string       name;
  } vec_t;

  vec_t tbl[14];
  logic [6:0] opList[6];

  initial begin
    tbl[0]  = '{OP_R,   3'd0, 1'b0, 0, 4, 0, pk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,2'd0,3'd0,1'b0,1'b0), "r_fetch"};
    tbl[1]  = '{OP_LW,  3'd2, 1'b0, 0, 5, 3, pk(1'b0,1'b1,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,3'd0,1'b0,1'b0), "lw_memread"};
    tbl[2]  = '{OP_LW,  3'd2, 1'b1, 1, 5, 4, pk(1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd0,2'd0,3'd0,1'b1,1'b0), "lw_memwb"};
    tbl[3]  = '{OP_SW,  3'd2, 1'b0, 0, 4, 3, pk(1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,2'd0,2'd1,3'd0,1'b0,1'b0), "sw_memwrite"};
    tbl[4]  = '{OP_R,   3'd0, 1'b1, 0, 4, 2, pk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,2'd0,3'd1,1'b0,1'b0), "r_sub"};
    tbl[5]  = '{OP_R,   3'd7, 1'b0, 0, 4, 2, pk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,2'd0,3'd2,1'b0,1'b0), "r_and"};
    tbl[6]  = '{OP_I,   3'd0, 1'b1, 0, 4, 2, pk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,2'd0,3'd0,1'b0,1'b0), "i_addi_b30"};
    tbl[7]  = '{OP_R,   3'd2, 1'b0, 1, 4, 2, pk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,2'd0,3'd5,1'b0,1'b0), "r_slt"};
    tbl[8]  = '{OP_I,   3'd6, 1'b0, 0, 4, 2, pk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,2'd0,3'd3,1'b0,1'b0), "i_ori"};
    tbl[9]  = '{OP_BEQ, 3'd0, 1'b0, 1, 3, 2, pk(1'b1,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,2'd2,3'd1,1'b0,1'b0), "beq_taken"};
    tbl[10] = '{OP_BEQ, 3'd0, 1'b0, 0, 3, 2, pk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,2'd2,3'd1,1'b0,1'b0), "beq_not"};
    tbl[11] = '{OP_JAL, 3'd0, 1'b0, 0, 4, 2, pk(1'b1,1'b0,1'b0,1'b0,2'd0,2'd1,2'd2,2'd3,3'd0,1'b0,1'b0), "jal_jump"};
    tbl[12] = '{OP_JAL, 3'd0, 1'b0, 1, 4, 3, pk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd3,3'd0,1'b1,1'b0), "jal_link"};
    tbl[13] = '{7'h7F,  3'd0, 1'b0, 1, 2, 1, pk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,2'd0,3'd0,1'b0,1'b1), "illegal"};
    opList[0] = OP_LW; opList[1] = OP_SW; opList[2] = OP_R;
    opList[3] = OP_I;  opList[4] = OP_BEQ; opList[5] = OP_JAL;

    // Reset held for three cycles with an R-type opcode present.
    reset = 1'b1; op = OP_R; funct3 = 3'd0; funct7b5 = 1'b1; Zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check(outs, 17'd0, $sformatf("reset_%0d", i));
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // Table-driven instructions, back to back.
    for (int i = 0; i < 14; i++)
      runInstr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].zero, tbl[i].cycles,
               tbl[i].keyK, tbl[i].keyExp, tbl[i].name);

    // Reset mid-lw (DUT now in MEMREAD) aborts it, then FETCH resumes.
    runInstr(OP_LW, 3'd2, 1'b0, 0, 3, -1, 17'd0, "lw_abort");
    reset = 1'b1;
    @(negedge clk);
    check(outs, 17'd0, "abort_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    runInstr(OP_SW, 3'd2, 1'b0, 0, 4, 0,
             pk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,2'd1,3'd0,1'b0,1'b0), "after_abort");

    // Randomized instruction stream, including arbitrary (mostly illegal) opcodes.
    for (int n = 0; n < 200; n++) begin
      logic [6:0] o;
      int sel;
      sel = int'($urandom_range(0, 6));
      o = (sel == 6) ? 7'($urandom_range(0, 127)) : opList[sel];
      runInstr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2, cpi(o),
               -1, 17'd0, $sformatf("rnd%0d", n));
    end

    // The last instruction must hand back to FETCH.
    runInstr(OP_I, 3'd0, 1'b0, 0, 1, -1, 17'd0, "final_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
